pong_core_param: RTL and testbench

Parametrised two-player pong game engine with a configurable playfield, paddle length, winning score and serve delay.
Runs on the single system clock and advances the game only on a one-cycle `tick` strobe, so it needs no divided clocks.
A state machine sequences IDLE, PLAY, POINT and GAMEOVER. Positions and scores are exported to the matrix scanner and the seven-segment score display.

---
 rtl/pong_core_param_if.sv | 33 +++
 rtl/pong_core_param.sv | 231 +++++++++++++++++++++++
 tb/tb_pong_core_param.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_core_param_if.sv
// Control and display bundle between the pong engine and its surroundings.
// The master side drives the strobe and player inputs and observes positions and scores.
interface pong_core_param_if #(
    parameter int XW      = 3,
    parameter int YW      = 3,
    parameter int SCORE_W = 4
);
    logic               tick;
    logic               up_p1;
    logic               down_p1;
    logic               up_p2;
    logic               down_p2;
    logic               serve;
    logic [XW-1:0]      p1_pos;
    logic [XW-1:0]      p2_pos;
    logic [XW-1:0]      ball_x;
    logic [YW-1:0]      ball_y;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [1:0]         state;
    logic [1:0]         winner;
    logic               point_pulse;

    modport master (
        output tick, up_p1, down_p1, up_p2, down_p2, serve,
        input  p1_pos, p2_pos, ball_x, ball_y, score_p1, score_p2, state, winner, point_pulse
    );

    modport slave (
        input  tick, up_p1, down_p1, up_p2, down_p2, serve,
        output p1_pos, p2_pos, ball_x, ball_y, score_p1, score_p2, state, winner, point_pulse
    );
endinterface

// File: rtl/pong_core_param.sv
// Two-player pong engine: paddles, ball, scoring and game sequencing,
// all advanced on a single-cycle tick strobe in the system clock domain.
module pong_core_param #(
    parameter int GRID_H      = 8,
    parameter int GRID_W      = 8,
    parameter int PADDLE_LEN  = 3,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 4,
    parameter int SCORE_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    pong_core_param_if.slave bus
);
    localparam int XW = $clog2(GRID_H);
    localparam int YW = $clog2(GRID_W);
    localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_POINT = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam logic [1:0] DX_ZERO = 2'b00;
    localparam logic [1:0] DX_POS  = 2'b01;
    localparam logic [1:0] DX_NEG  = 2'b11;

    localparam logic [XW-1:0]      CTR      = XW'((GRID_H - PADDLE_LEN) / 2);
    localparam logic [XW-1:0]      PAD_MAX  = XW'(GRID_H - PADDLE_LEN);
    localparam logic [XW-1:0]      ROW_CTR  = XW'(GRID_H / 2);
    localparam logic [XW-1:0]      ROW_LAST = XW'(GRID_H - 1);
    localparam logic [YW-1:0]      COL_CTR  = YW'(GRID_W / 2);
    localparam logic [YW-1:0]      COL_LAST = YW'(GRID_W - 1);
    localparam logic [XW:0]        OFF_LAST = (XW+1)'(PADDLE_LEN - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [CW-1:0]      CNT_LAST = CW'(SERVE_DELAY - 1);

    logic [XW-1:0]      p1_pos_r, p2_pos_r, ball_x_r, p1_s, p2_s, ball_x_s, pad_s;
    logic [YW-1:0]      ball_y_r, ball_y_s;
    logic [1:0]         dir_x_r, dir_x_s, dx_defl_s;
    logic               dir_y_r, dir_y_s;
    logic [SCORE_W-1:0] score_p1_r, score_p2_r, score_p1_s, score_p2_s;
    logic [1:0]         state_r, state_s, winner_r, winner_s;
    logic               point_pulse_r, pulse_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic               at_p1_s, at_p2_s, hit_s;
    logic [XW:0]        off_s;

    function automatic logic [XW-1:0] paddle_next(input logic [XW-1:0] pos,
                                                  input logic up, input logic dn);
        logic [XW-1:0] res;
        if (up && !dn && (pos != '0)) begin
            res = pos - XW'(1);
        end else if (dn && !up && (pos < PAD_MAX)) begin
            res = pos + XW'(1);
        end else begin
            res = pos;
        end
        return res;
    endfunction

    // Next-state evaluation for one tick, using only pre-tick registers.
    always_comb begin
        p1_s       = p1_pos_r;
        p2_s       = p2_pos_r;
        ball_x_s   = ball_x_r;
        ball_y_s   = ball_y_r;
        dir_x_s    = dir_x_r;
        dir_y_s    = dir_y_r;
        dx_defl_s  = dir_x_r;
        score_p1_s = score_p1_r;
        score_p2_s = score_p2_r;
        state_s    = state_r;
        winner_s   = winner_r;
        cnt_s      = cnt_r;
        pulse_s    = 1'b0;
        at_p1_s    = (ball_y_r == '0) && !dir_y_r;
        at_p2_s    = (ball_y_r == COL_LAST) && dir_y_r;
        pad_s      = at_p1_s ? p1_pos_r : p2_pos_r;
        off_s      = {1'b0, ball_x_r} - {1'b0, pad_s};
        hit_s      = (ball_x_r >= pad_s) && (off_s <= OFF_LAST);

        if (state_r != ST_OVER) begin
            p1_s = paddle_next(p1_pos_r, bus.up_p1, bus.down_p1);
            p2_s = paddle_next(p2_pos_r, bus.up_p2, bus.down_p2);
        end else begin
            p1_s = p1_pos_r;
            p2_s = p2_pos_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (bus.serve) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if ((at_p1_s || at_p2_s) && !hit_s) begin
                    // Miss: recentre everything and serve toward whoever scored.
                    pulse_s  = 1'b1;
                    ball_x_s = ROW_CTR;
                    ball_y_s = COL_CTR;
                    dir_x_s  = DX_ZERO;
                    dir_y_s  = at_p1_s;
                    p1_s     = CTR;
                    p2_s     = CTR;
                    cnt_s    = '0;
                    if (at_p2_s) begin
                        score_p1_s = score_p1_r + SCORE_W'(1);
                        if (score_p1_s == WIN) begin
                            state_s  = ST_OVER;
                            winner_s = 2'b01;
                        end else begin
                            state_s  = ST_POINT;
                        end
                    end else begin
                        score_p2_s = score_p2_r + SCORE_W'(1);
                        if (score_p2_s == WIN) begin
                            state_s  = ST_OVER;
                            winner_s = 2'b10;
                        end else begin
                            state_s  = ST_POINT;
                        end
                    end
                end else begin
                    if (at_p1_s || at_p2_s) begin
                        dir_y_s = !dir_y_r;
                        if (PADDLE_LEN > 1) begin
                            if (off_s == '0) begin
                                dx_defl_s = DX_NEG;
                            end else if (off_s == OFF_LAST) begin
                                dx_defl_s = DX_POS;
                            end else begin
                                dx_defl_s = DX_ZERO;
                            end
                        end else begin
                            dx_defl_s = dir_x_r;
                        end
                    end else begin
                        dir_y_s   = dir_y_r;
                        dx_defl_s = dir_x_r;
                    end
                    // Wall after deflection keeps corner hits inside the grid.
                    if ((ball_x_r == '0) && (dx_defl_s == DX_NEG)) begin
                        dir_x_s = DX_POS;
                    end else if ((ball_x_r == ROW_LAST) && (dx_defl_s == DX_POS)) begin
                        dir_x_s = DX_NEG;
                    end else begin
                        dir_x_s = dx_defl_s;
                    end
                    case (dir_x_s)
                        DX_POS:  ball_x_s = ball_x_r + XW'(1);
                        DX_NEG:  ball_x_s = ball_x_r - XW'(1);
                        default: ball_x_s = ball_x_r;
                    endcase
                    if (dir_y_s) begin
                        ball_y_s = ball_y_r + YW'(1);
                    end else begin
                        ball_y_s = ball_y_r - YW'(1);
                    end
                end
            end
            ST_POINT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_PLAY;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_OVER: begin
                if (bus.serve) begin
                    state_s    = ST_IDLE;
                    score_p1_s = '0;
                    score_p2_s = '0;
                    winner_s   = 2'b00;
                    p1_s       = CTR;
                    p2_s       = CTR;
                    dir_y_s    = 1'b1;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Game registers: reset wins over tick; the point pulse lasts a single clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_pos_r      <= CTR;
            p2_pos_r      <= CTR;
            ball_x_r      <= ROW_CTR;
            ball_y_r      <= COL_CTR;
            dir_x_r       <= DX_ZERO;
            dir_y_r       <= 1'b1;
            score_p1_r    <= '0;
            score_p2_r    <= '0;
            state_r       <= ST_IDLE;
            winner_r      <= 2'b00;
            cnt_r         <= '0;
            point_pulse_r <= 1'b0;
        end else if (bus.tick) begin
            p1_pos_r      <= p1_s;
            p2_pos_r      <= p2_s;
            ball_x_r      <= ball_x_s;
            ball_y_r      <= ball_y_s;
            dir_x_r       <= dir_x_s;
            dir_y_r       <= dir_y_s;
            score_p1_r    <= score_p1_s;
            score_p2_r    <= score_p2_s;
            state_r       <= state_s;
            winner_r      <= winner_s;
            cnt_r         <= cnt_s;
            point_pulse_r <= pulse_s;
        end else begin
            point_pulse_r <= 1'b0;
        end
    end

    assign bus.p1_pos      = p1_pos_r;
    assign bus.p2_pos      = p2_pos_r;
    assign bus.ball_x      = ball_x_r;
    assign bus.ball_y      = ball_y_r;
    assign bus.score_p1    = score_p1_r;
    assign bus.score_p2    = score_p2_r;
    assign bus.state       = state_r;
    assign bus.winner      = winner_r;
    assign bus.point_pulse = point_pulse_r;
endmodule

// File: tb/tb_pong_core_param.sv
// Scoreboard bench for pong_core_param (8x8, paddle 3, win at 3, serve delay 4).
module tb_pong_core_param;
    localparam int H = 8, W = 8, L = 3, WS = 3, SD = 4;
    localparam int CTR = (H - L) / 2;

    typedef struct {
        int p1; int p2; int bx; int by; int s1; int s2; int st; int win; int pulse;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_st, m_win, m_cnt, m_pulse;

    pong_core_param_if #(.XW(3), .YW(3), .SCORE_W(4)) bus ();

    pong_core_param #(
        .GRID_H(H), .GRID_W(W), .PADDLE_LEN(L),
        .WIN_SCORE(WS), .SERVE_DELAY(SD), .SCORE_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.p1 = m_p1; e.p2 = m_p2; e.bx = m_bx; e.by = m_by;
        e.s1 = m_s1; e.s2 = m_s2; e.st = m_st; e.win = m_win; e.pulse = m_pulse;
        return e;
    endfunction

    function automatic int pad_move(input int pos, input bit up, input bit dn);
        if (up && !dn && pos > 0) return pos - 1;
        if (dn && !up && pos < H - L) return pos + 1;
        return pos;
    endfunction

    task automatic model_reset();
        m_p1 = CTR; m_p2 = CTR; m_bx = H / 2; m_by = W / 2; m_dx = 0; m_dy = 1;
        m_s1 = 0; m_s2 = 0; m_st = 0; m_win = 0; m_cnt = 0; m_pulse = 0;
    endtask

    task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2,
                              input bit srv);
        int o1, o2, ndx, ndy, scorer;
        bit miss;
        m_pulse = 0;
        if (m_st == 3) begin
            if (srv) begin
                m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_p1 = CTR; m_p2 = CTR; m_dy = 1;
            end
            return;
        end
        o1 = m_p1;
        o2 = m_p2;
        m_p1 = pad_move(o1, u1, d1);
        m_p2 = pad_move(o2, u2, d2);
        if (m_st == 0) begin
            if (srv) m_st = 1;
        end else if (m_st == 2) begin
            if (m_cnt == SD - 1) m_st = 1;
            else m_cnt++;
        end else begin
            ndx = m_dx; ndy = m_dy; miss = 0; scorer = 0;
            if (m_by == 0 && m_dy == -1) begin
                if (m_bx >= o1 && m_bx <= o1 + L - 1) begin
                    ndy = 1;
                    if (L > 1) ndx = (m_bx == o1) ? -1 : ((m_bx == o1 + L - 1) ? 1 : 0);
                end else begin
                    miss = 1; scorer = 2;
                end
            end else if (m_by == W - 1 && m_dy == 1) begin
                if (m_bx >= o2 && m_bx <= o2 + L - 1) begin
                    ndy = -1;
                    if (L > 1) ndx = (m_bx == o2) ? -1 : ((m_bx == o2 + L - 1) ? 1 : 0);
                end else begin
                    miss = 1; scorer = 1;
                end
            end
            if (miss) begin
                m_pulse = 1; m_bx = H / 2; m_by = W / 2; m_dx = 0;
                m_dy = (scorer == 1) ? -1 : 1;
                m_p1 = CTR; m_p2 = CTR;
                if (scorer == 1) m_s1++;
                else m_s2++;
                if (m_s1 == WS || m_s2 == WS) begin
                    m_st = 3; m_win = scorer;
                end else begin
                    m_st = 2; m_cnt = 0;
                end
            end else begin
                if (m_bx == 0 && ndx == -1) ndx = 1;
                else if (m_bx == H - 1 && ndx == 1) ndx = -1;
                m_dx = ndx; m_dy = ndy;
                m_bx += ndx; m_by += ndy;
            end
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check_val({tag, "_qsize"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({tag, "_p1"},     int'(bus.p1_pos),      e.p1);
            check_val({tag, "_p2"},     int'(bus.p2_pos),      e.p2);
            check_val({tag, "_bx"},     int'(bus.ball_x),      e.bx);
            check_val({tag, "_by"},     int'(bus.ball_y),      e.by);
            check_val({tag, "_s1"},     int'(bus.score_p1),    e.s1);
            check_val({tag, "_s2"},     int'(bus.score_p2),    e.s2);
            check_val({tag, "_state"},  int'(bus.state),       e.st);
            check_val({tag, "_winner"}, int'(bus.winner),      e.win);
            check_val({tag, "_pulse"},  int'(bus.point_pulse), e.pulse);
        end
    endtask

    task automatic clear_inputs();
        bus.tick = 1'b0; bus.up_p1 = 1'b0; bus.down_p1 = 1'b0;
        bus.up_p2 = 1'b0; bus.down_p2 = 1'b0; bus.serve = 1'b0;
    endtask

    task automatic do_tick(input bit u1, input bit d1, input bit u2, input bit d2,
                           input bit srv);
        @(negedge clk);
        bus.up_p1 = u1; bus.down_p1 = d1; bus.up_p2 = u2; bus.down_p2 = d2;
        bus.serve = srv; bus.tick = 1'b1;
        model_tick(u1, d1, u2, d2, srv);
        sb_q.push_back(snap());
        @(posedge clk);
        #1;
        clear_inputs();
        pop_check("tick");
    endtask

    task automatic idle_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.up_p1 = 1'b1; bus.serve = 1'b1;
            m_pulse = 0;
            sb_q.push_back(snap());
            @(posedge clk);
            #1;
            clear_inputs();
            pop_check("idle");
        end
    endtask

    task automatic do_reset(input bit with_tick);
        @(negedge clk);
        reset = 1'b1;
        bus.tick = with_tick;
        model_reset();
        sb_q.push_back(snap());
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        pop_check("reset");
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state and quiescence without tick
        do_reset(1'b0);
        check_val("rst_p1", int'(bus.p1_pos), 2);
        check_val("rst_p2", int'(bus.p2_pos), 2);
        check_val("rst_bx", int'(bus.ball_x), 4);
        check_val("rst_by", int'(bus.ball_y), 4);
        check_val("rst_state", int'(bus.state), 0);
        idle_clks(10);

        // Paddle clamping
        for (int i = 0; i < 4; i++) do_tick(1, 0, 0, 0, 0);
        check_val("clamp_top", int'(bus.p1_pos), 0);
        for (int i = 0; i < 8; i++) do_tick(0, 1, 0, 0, 0);
        check_val("clamp_bottom", int'(bus.p1_pos), 5);
        do_tick(0, 0, 1, 1, 0);
        check_val("both_hold", int'(bus.p2_pos), 2);
        for (int i = 0; i < 3; i++) do_tick(1, 0, 0, 0, 0);

        // P2 misses
        do_tick(0, 0, 1, 0, 0);
        do_tick(0, 0, 1, 0, 0);
        check_val("p2_parked", int'(bus.p2_pos), 0);
        do_tick(0, 0, 0, 0, 1);
        check_val("serve_state", int'(bus.state), 1);
        check_val("serve_by", int'(bus.ball_y), 4);
        for (int i = 0; i < 3; i++) begin
            do_tick(0, 0, 0, 0, 0);
            check_val("fly_by", int'(bus.ball_y), 5 + i);
        end
        do_tick(0, 0, 0, 0, 0);
        check_val("miss_s1", int'(bus.score_p1), 1);
        check_val("miss_pulse", int'(bus.point_pulse), 1);
        check_val("miss_state", int'(bus.state), 2);
        check_val("miss_p2", int'(bus.p2_pos), 2);
        idle_clks(1);
        check_val("pulse_clear", int'(bus.point_pulse), 0);
        for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 0, 1);
        check_val("point_hold", int'(bus.state), 2);
        do_tick(0, 0, 0, 0, 0);
        check_val("point_done", int'(bus.state), 1);
        do_tick(0, 0, 0, 0, 0);
        check_val("serve_dir", int'(bus.ball_y), 3);

        // Edge deflection off P1, then wall bounce
        do_tick(0, 1, 0, 0, 1);
        do_tick(0, 1, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        check_val("defl_bx", int'(bus.ball_x), 3);
        check_val("defl_by", int'(bus.ball_y), 1);
        for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 0, 0);
        check_val("wall_bx0", int'(bus.ball_x), 0);
        do_tick(0, 0, 0, 0, 0);
        check_val("wall_bx", int'(bus.ball_x), 1);
        check_val("wall_by", int'(bus.ball_y), 5);

        // P1 keeps missing until the game ends
        for (int i = 0; i < 400 && m_st != 3; i++) do_tick(0, 1, 0, 0, 0);
        check_val("go_state", int'(bus.state), 3);
        check_val("go_s2", int'(bus.score_p2), 3);
        check_val("go_winner", int'(bus.winner), 2);
        for (int i = 0; i < 3; i++) do_tick(1, 0, 0, 1, 0);
        check_val("frozen_p1", int'(bus.p1_pos), 2);
        do_tick(0, 0, 0, 0, 1);
        check_val("restart_state", int'(bus.state), 0);
        check_val("restart_s2", int'(bus.score_p2), 0);

        // Reset precedence over tick mid-play
        do_tick(0, 0, 0, 0, 1);
        do_tick(0, 0, 0, 0, 0);
        do_tick(0, 0, 0, 0, 0);
        do_reset(1'b1);
        check_val("rst2_state", int'(bus.state), 0);
        check_val("rst2_by", int'(bus.ball_y), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
